sp_ram_bist: RTL and testbench

Word-level March C- built-in self-test initiator for the data/instruction RAM port. Drives the same en/addr/wdata/we/be/bypass request interface that `sp_ram_wrap` accepts, consumes its 1-cycle-latency read data, and reports pass/fail with first-failure capture. It sits between the SoC RAM request mux and `sp_ram_wrap`; the mux hands the port to this block while `busy_o` is high.

---
 rtl/sp_ram_bist_if.sv | 32 +++
 rtl/sp_ram_bist.sv | 197 +++++++++++++++++++
 tb/tb_sp_ram_bist.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_bist_if.sv
// sp_ram_bist_if: request/response bundle between the March C- BIST initiator and the
// single-port RAM wrapper.
//   en        - RAM enable (access issued this cycle)
//   addr      - byte address, word aligned
//   wdata     - write data
//   we        - 1 = write, 0 = read
//   be        - byte enables
//   bypass_en - wrapper bypass request
//   rdata     - read data, valid the cycle after a read is issued
// Modports: master = BIST (request driver), slave = RAM side.
interface sp_ram_bist_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                      en;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic                      bypass_en;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output en, addr, wdata, we, be, bypass_en,
        input  rdata
    );

    modport slave (
        input  en, addr, wdata, we, be, bypass_en,
        output rdata
    );
endinterface

// File: rtl/sp_ram_bist.sv
// sp_ram_bist: word-level March C- self-test initiator for a single-port RAM.
// Runs M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0),
// comparing each read one cycle later and stopping at the first mismatch.
// Ports:
//   clk          - clock
//   rstn_i       - synchronous active-low reset
//   start_i      - start request, honoured only when idle or done
//   busy_o       - test running
//   done_o       - test finished (level, held until the next start)
//   pass_o       - 1 = no mismatch, valid while done_o
//   fail_addr_o  - byte address of the first mismatching read
//   fail_rdata_o - data returned by that read
//   fail_exp_o   - data expected from that read
//   mem          - RAM request bundle (master side)
module sp_ram_bist #(
    parameter int unsigned          RAM_SIZE   = 32768,
    parameter int unsigned          ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN = 32'h5555_5555
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_rdata_o,
    output logic [DATA_WIDTH-1:0] fail_exp_o,
    sp_ram_bist_if.master         mem
);

    localparam int unsigned NumWords = RAM_SIZE / 4;
    localparam int unsigned IdxW     = ADDR_WIDTH - 2;

    typedef logic [IdxW-1:0] idx_t;
    localparam idx_t IdxLast = idx_t'(NumWords - 1);

    typedef enum logic [3:0] {
        StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StDrain, StDone
    } state_e;

    state_e                state_q, state_d;
    idx_t                  idx_q, idx_d;
    logic                  phase_q, phase_d;       // 0 = read half, 1 = write half of (r,w)
    logic                  rd_vld_q, rd_vld_d;     // a read was issued last cycle
    logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_rdata_q, fail_rdata_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;

    logic                  mismatch;
    logic                  up_elem;
    logic                  elem_end;
    logic [DATA_WIDTH-1:0] rw_exp;
    logic [ADDR_WIDTH-1:0] cur_addr;

    assign cur_addr = {idx_q, 2'b00};
    assign mismatch = rd_vld_q && (mem.rdata != rd_exp_q);
    assign up_elem  = (state_q == StM1) || (state_q == StM2);
    assign elem_end = up_elem ? (idx_q == IdxLast) : (idx_q == '0);
    // M1/M3 read the background, M2/M4 read its complement
    assign rw_exp   = ((state_q == StM1) || (state_q == StM3)) ? BG_PATTERN : ~BG_PATTERN;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        rd_vld_d     = 1'b0;
        rd_exp_d     = rd_exp_q;
        rd_addr_d    = rd_addr_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_rdata_d = fail_rdata_q;
        fail_exp_d   = fail_exp_q;
        mem.en        = 1'b0;
        mem.we        = 1'b0;
        mem.wdata     = '0;
        mem.addr      = '0;
        mem.be        = '0;
        mem.bypass_en = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StM0;
                    idx_d        = '0;
                    phase_d      = 1'b0;
                    pass_d       = 1'b1;
                    fail_addr_d  = '0;
                    fail_rdata_d = '0;
                    fail_exp_d   = '0;
                end
            end
            StM0: begin
                mem.en    = 1'b1;
                mem.we    = 1'b1;
                mem.wdata = BG_PATTERN;
                if (idx_q == IdxLast) begin
                    state_d = StM1;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end
            StM1, StM2, StM3, StM4: begin
                mem.en = 1'b1;
                mem.we = phase_q;
                if (!phase_q) begin
                    rd_vld_d  = 1'b1;
                    rd_exp_d  = rw_exp;
                    rd_addr_d = cur_addr;
                    phase_d   = 1'b1;
                end else begin
                    mem.wdata = ~rw_exp;
                    phase_d   = 1'b0;
                    if (elem_end) begin
                        unique case (state_q)
                            StM1:    begin state_d = StM2; idx_d = '0;      end
                            StM2:    begin state_d = StM3; idx_d = IdxLast; end
                            StM3:    begin state_d = StM4; idx_d = IdxLast; end
                            default: begin state_d = StM5; idx_d = '0;      end
                        endcase
                    end else if (up_elem) begin
                        idx_d = idx_q + idx_t'(1);
                    end else begin
                        idx_d = idx_q - idx_t'(1);
                    end
                end
            end
            StM5: begin
                mem.en    = 1'b1;
                rd_vld_d  = 1'b1;
                rd_exp_d  = BG_PATTERN;
                rd_addr_d = cur_addr;
                if (idx_q == IdxLast) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (mem.en) begin
            mem.addr = cur_addr;
            mem.be   = '1;
        end

        // The access driven this cycle still completes; nothing issues afterwards.
        if (mismatch) begin
            state_d      = StDone;
            rd_vld_d     = 1'b0;
            pass_d       = 1'b0;
            fail_addr_d  = rd_addr_q;
            fail_rdata_d = mem.rdata;
            fail_exp_d   = rd_exp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            phase_q      <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_exp_q     <= '0;
            rd_addr_q    <= '0;
            pass_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_rdata_q <= '0;
            fail_exp_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            rd_vld_q     <= rd_vld_d;
            rd_exp_q     <= rd_exp_d;
            rd_addr_q    <= rd_addr_d;
            pass_q       <= pass_d;
            fail_addr_q  <= fail_addr_d;
            fail_rdata_q <= fail_rdata_d;
            fail_exp_q   <= fail_exp_d;
        end
    end

    assign busy_o       = (state_q != StIdle) && (state_q != StDone);
    assign done_o       = (state_q == StDone);
    assign pass_o       = done_o && pass_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_rdata_o = fail_rdata_q;
    assign fail_exp_o   = fail_exp_q;

endmodule

// File: tb/tb_sp_ram_bist.sv
// tb_sp_ram_bist: bench for sp_ram_bist with a 16-word RAM model and injectable faults
// (0 = none, 1 = word 5 bit 3 stuck-at-0, 2 = writes to word 9 land in word 1).
// Each run pushes its hand-computed result into a queue; a monitor pops it when done_o rises.
module tb_sp_ram_bist;

    localparam logic [31:0] BG = 32'h5555_5555;

    typedef struct {
        logic        pass;
        logic [5:0]  faddr;
        logic [31:0] frdata;
        logic [31:0] fexp;
        int          lat;
        int          en_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, pass_o;
    logic [5:0]  fail_addr_o;
    logic [31:0] fail_rdata_o, fail_exp_o;

    sp_ram_bist_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    sp_ram_bist #(
        .RAM_SIZE(64), .ADDR_WIDTH(6), .DATA_WIDTH(32), .BG_PATTERN(BG)
    ) dut (
        .clk(clk), .rstn_i(rstn_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_addr_o(fail_addr_o), .fail_rdata_o(fail_rdata_o), .fail_exp_o(fail_exp_o),
        .mem(bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   prot_errs = 0;
    int   fault = 0;
    logic fill_req = 1'b0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // RAM model, 1-cycle read latency
    logic [31:0] ram [16];
    always @(posedge clk) begin
        logic [3:0]  widx;
        logic [31:0] d;
        if (fill_req) begin
            for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        end else if (bus.en) begin
            widx = bus.addr[5:2];
            if (bus.we) begin
                if (fault == 2 && widx == 4'd9) widx = 4'd1;
                d = bus.wdata;
                if (fault == 1 && widx == 4'd5) d[3] = 1'b0;
                ram[widx] = d;
            end else begin
                d = ram[widx];
                if (fault == 1 && widx == 4'd5) d[3] = 1'b0;
                bus.rdata <= d;
            end
        end
    end

    // Reference March C- access for cycle k (1..160) after the start edge
    function automatic void model(input int k, output logic mwe, output logic [5:0] ma,
                                  output logic [31:0] mwd);
        int idx, t, e;
        mwe = 1'b0;
        mwd = 32'h0;
        if (k <= 16) begin
            idx = k - 1;
            mwe = 1'b1;
            mwd = BG;
        end else if (k <= 144) begin
            t   = k - 17;
            e   = t / 32;
            idx = (t % 32) / 2;
            if (e >= 2) idx = 15 - idx;
            mwe = (t % 2) == 1;
            mwd = (e % 2 == 0) ? ~BG : BG;
        end else begin
            idx = k - 145;
        end
        ma = 6'(idx * 4);
    endfunction

    // Monitor: protocol, access order, and scoreboard pop on done_o rising
    int   cyc = 0, en_cnt = 0, seq_errs = 0;
    bit   in_run = 1'b0;
    logic busy_p = 1'b0, done_p = 1'b0;
    always @(negedge clk) begin
        logic        mwe;
        logic [5:0]  ma;
        logic [31:0] mwd;
        exp_t        e;
        if (bus.bypass_en !== 1'b0) prot_errs++;
        if (bus.en && (bus.addr[1:0] !== 2'b00 || bus.be !== 4'hF || !busy_o)) prot_errs++;
        if (!bus.en && bus.be !== 4'h0) prot_errs++;
        if (!rstn_i) begin
            in_run = 1'b0;
        end else begin
            if (busy_o && !busy_p) begin
                in_run = 1'b1; cyc = 1; en_cnt = 0; seq_errs = 0;
            end else if (in_run) begin
                cyc++;
            end
            if (in_run && bus.en) begin
                en_cnt++;
                if (cyc > 160) begin
                    seq_errs++;
                end else begin
                    model(cyc, mwe, ma, mwd);
                    if (bus.we !== mwe || bus.addr !== ma || (mwe && bus.wdata !== mwd))
                        seq_errs++;
                end
            end
            if (in_run && done_o && !done_p) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pass_o", 64'(pass_o), 64'(e.pass));
                    check("fail_addr_o", 64'(fail_addr_o), 64'(e.faddr));
                    check("fail_rdata_o", 64'(fail_rdata_o), 64'(e.frdata));
                    check("fail_exp_o", 64'(fail_exp_o), 64'(e.fexp));
                    check("run_latency", 64'(cyc - 1), 64'(e.lat));
                    check("mem_en_cycles", 64'(en_cnt), 64'(e.en_cnt));
                    check("access_seq_errs", 64'(seq_errs), 64'd0);
                end
                in_run = 1'b0;
            end else if (in_run && !busy_o && !done_o) begin
                in_run = 1'b0;
            end
        end
        busy_p = busy_o;
        done_p = done_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input int f);
        fault = f;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    task automatic start_run(input logic p, input logic [5:0] fa, input logic [31:0] fr,
                             input logic [31:0] fe, input int lat, input int enc, input bit push);
        exp_t e;
        e.pass = p; e.faddr = fa; e.frdata = fr; e.fexp = fe; e.lat = lat; e.en_cnt = enc;
        if (push) sb_q.push_back(e);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 400) begin
            tick();
            n++;
        end
        if (!done_o) check("done_timeout", 64'd0, 64'd1);
        tick();
        tick();
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_status"}, {61'd0, busy_o, done_o, pass_o}, 64'd0);
        check({tag, "_fail_addr"}, 64'(fail_addr_o), 64'd0);
        check({tag, "_fail_data"}, {fail_rdata_o, fail_exp_o}, 64'd0);
        check({tag, "_mem_ctl"}, {58'd0, bus.en, bus.we, bus.be}, 64'd0);
        check({tag, "_mem_bus"}, {26'd0, bus.addr, bus.wdata}, 64'd0);
    endtask

    initial begin
        int en_seen;
        repeat (3) tick();
        check_all_reset("reset");
        rstn_i = 1'b1;
        tick();

        // Fault-free run
        prep(0);
        start_run(1'b1, 6'h00, 32'h0, 32'h0, 161, 160, 1'b1);
        wait_done();

        // Stuck-at-0 bit 3 of word 5: caught in M2 read of word 5; start from DONE
        prep(1);
        start_run(1'b0, 6'h14, 32'hAAAA_AAA2, 32'hAAAA_AAAA, 60, 60, 1'b1);
        check("done_drops_on_restart", 64'(done_o), 64'd0);
        wait_done();

        // Write to word 9 lands in word 1: word 9 still 0 at its M1 read
        prep(2);
        start_run(1'b0, 6'h24, 32'h0, BG, 36, 36, 1'b1);
        check("capture_cleared_on_start", 64'(fail_addr_o), 64'd0);
        wait_done();

        // Reset mid-test
        prep(0);
        start_run(1'b0, 6'h0, 32'h0, 32'h0, 0, 0, 1'b0);
        repeat (49) tick();
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        check_all_reset("midreset");
        en_seen = 0;
        repeat (8) begin
            tick();
            if (bus.en || busy_o) en_seen++;
        end
        check("idle_after_reset", 64'(en_seen), 64'd0);
        start_run(1'b1, 6'h00, 32'h0, 32'h0, 161, 160, 1'b1);
        wait_done();

        // start_i while busy is ignored
        prep(0);
        start_run(1'b1, 6'h00, 32'h0, 32'h0, 161, 160, 1'b1);
        repeat (20) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done();

        // Failing run, then a clean restart from DONE
        prep(1);
        start_run(1'b0, 6'h14, 32'hAAAA_AAA2, 32'hAAAA_AAAA, 60, 60, 1'b1);
        wait_done();
        check("fail_held_in_done", 64'(fail_addr_o), 64'h14);
        prep(0);
        start_run(1'b1, 6'h00, 32'h0, 32'h0, 161, 160, 1'b1);
        check("restart_clears_fail", {fail_rdata_o, fail_exp_o}, 64'd0);
        wait_done();

        check("protocol_errs", 64'(prot_errs), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
